// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//   IF/ID pipeline register between instruction fetch and decode.
//   A main entry drives the decode-side outputs directly (all outputs are
//   registered). A one-entry skid buffer catches the beat that fetch may
//   still launch in the cycle decode starts to backpressure, so no beat is
//   lost and in_ready can be a plain register. A synchronous flush squashes
//   both entries and any beat arriving in the same cycle. Whenever no valid
//   instruction is held the output instruction is forced to NOP_INSTR.
//
// Ports
//   clk, rst        clock / synchronous active-high reset
//   flush           squash held and incoming beats
//   in_valid/ready  fetch-side handshake (in_ready = NOT skid valid)
//   in_pc, in_instr incremented PC and instruction from fetch
//   out_valid/ready decode-side handshake
//   out_pc          in_pc - PC_ADJUST of the held beat
//   out_instr       held instruction, NOP_INSTR when out_valid = 0
//   stall_count     saturating count of out_valid & ~out_ready cycles
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int unsigned                 PC_W      = 8,
    parameter int unsigned                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]          NOP_INSTR = 32'hF800_0000,
    parameter int unsigned                 PC_ADJUST = 1,
    parameter int unsigned                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_count
);

    // Fetch hands us the already-incremented PC; the adjustment wraps mod 2^PC_W.
    localparam logic [PC_W-1:0] ADJ = PC_W'(PC_ADJUST);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } beat_t;

    logic  m_valid, s_valid;
    beat_t m_beat,  s_beat;
    beat_t in_beat;
    logic  acc, adv;
    logic  [CNT_W-1:0] stall_cnt;

    assign in_beat.pc    = in_pc - ADJ;
    assign in_beat.instr = in_instr;

    // in_ready is a function of a register only, so it is glitch-free and
    // breaks the combinational path from out_ready back to fetch.
    assign in_ready = ~s_valid;
    assign acc      = in_valid & in_ready;
    assign adv      = out_ready | ~m_valid;

    // Main / skid entries
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_beat  <= '{pc: '0, instr: NOP_INSTR};
            s_valid <= 1'b0;
            s_beat  <= '{pc: '0, instr: NOP_INSTR};
        end else if (flush) begin
            // Squash everything, including a beat accepted this cycle.
            m_valid <= 1'b0;
            m_beat  <= '{pc: '0, instr: NOP_INSTR};
            s_valid <= 1'b0;
        end else if (adv) begin
            if (s_valid) begin
                // Oldest beat first: the skid always drains before new input.
                m_valid <= 1'b1;
                m_beat  <= s_beat;
                s_valid <= acc;
                if (acc) s_beat <= in_beat;
            end else if (acc) begin
                m_valid <= 1'b1;
                m_beat  <= in_beat;
            end else begin
                // Bubble: keep the last PC, present a NOP.
                m_valid      <= 1'b0;
                m_beat.instr <= NOP_INSTR;
            end
        end else if (acc) begin
            // Main held under backpressure; park the in-flight beat.
            s_valid <= 1'b1;
            s_beat  <= in_beat;
        end
    end

    // Stall counter: only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = m_valid;
    assign out_pc      = m_beat.pc;
    assign out_instr   = m_beat.instr;
    assign stall_count = stall_cnt;

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register for the processor front end. It sits between instruction fetch and decode.
- Carries the fetched PC and instruction word with a valid/ready handshake.
- Holds its contents under decode backpressure through a one-entry skid buffer, so no fetch beat is lost.
- Supports a synchronous flush for branch/jump squash and inserts a NOP instruction whenever no valid instruction is held.
- Keeps a saturating count of backpressure stall cycles.

Parameters:
PC_W, 8, width of PC fields
INSTR_W, 32, width of instruction fields
NOP_INSTR, 32'hF800_0000, instruction word presented when the output is invalid and after reset or flush
PC_ADJUST, 1, constant subtracted from in_pc before storing (fetch supplies the incremented PC)
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous squash of all held and incoming instructions
in_valid  in  1  fetch presents a beat
in_ready  out  1  block can accept a beat; registered, equals NOT skid_valid
in_pc  in  PC_W  incremented PC from fetch
in_instr  in  INSTR_W  fetched instruction
out_valid  out  1  decode-side beat valid
out_ready  in  1  decode accepts the beat
out_pc  out  PC_W  stored PC (in_pc - PC_ADJUST)
out_instr  out  INSTR_W  stored instruction; NOP_INSTR when out_valid=0
stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- State: main entry (m_valid, m_pc, m_instr) drives the outputs directly, and all outputs are registered. Skid entry (s_valid, s_pc, s_instr) is internal.
- Reset (rst=1, priority over everything):
  - m_valid=0, s_valid=0.
  - out_pc=0, out_instr=NOP_INSTR, in_ready=1, stall_count=0.
  - Input is ignored during the reset cycle.
- Accept: acc = in_valid AND in_ready. Stored PC = (in_pc - PC_ADJUST) mod 2^PC_W. For example, in_pc=0 gives 8'hFF.
- Advance condition: adv = out_ready OR NOT m_valid.
- When adv=1:
  - If s_valid, main loads the skid entry and the skid clears. If acc is also true in that cycle, the input goes into the skid; this case cannot occur because in_ready=0 whenever s_valid=1.
  - Else if acc, main loads the input.
  - Else m_valid=0, out_pc holds its value, out_instr=NOP_INSTR.
- When adv=0 (main held under backpressure):
  - Main entry is unchanged.
  - If acc, the skid loads the input and in_ready drops to 0 on the next cycle.
- Latency: 1 cycle from acceptance to out_valid when out_ready=1. Sustained throughput is 1 beat/cycle.
- Ordering is strictly FIFO: a skid beat always reaches main before any newer beat.
- Flush (rst=0, flush=1):
  - m_valid=0, s_valid=0, out_instr=NOP_INSTR, out_pc=0.
  - A beat accepted in the flush cycle is discarded.
  - in_ready=1 on the next cycle.
  - Flush takes priority over acceptance and advance.
- Stall counter:
  - Increments when out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Flush does not clear it; only rst does.
- out_instr is never X after reset. Beats with in_valid=0 never modify state.

Test Plan:
- Reset then stream: rst for 2 cycles, then in_valid=1, out_ready=1, in_pc=1,2,3 and in_instr=A0000001..3 on consecutive cycles -> out_valid rises 1 cycle later, out_pc=0,1,2 with matching instructions, in_ready constantly 1, stall_count=0.
- Backpressure/skid: beat P=5 accepted, out_ready=0 for 3 cycles while beats P=6 and P=7 are offered:
  - P=6 goes to the skid and in_ready drops.
  - P=7 is held off until space is available.
  - out_pc holds 4 throughout, and stall_count=3.
  - After out_ready=1, the outputs are 4, 5, 6 in order with no loss or duplication.
- Flush with full skid: main and skid both valid, flush=1 with in_valid=1 -> next cycle out_valid=0, out_instr=F8000000, in_ready=1, out_pc=0; none of the three beats ever appears.
- PC wrap: in_pc=8'h00 -> out_pc=8'hFF. With PC_ADJUST=0, in_pc=8'h00 -> out_pc=8'h00.
- Counter saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count stops at 15. Then flush -> stall_count remains 15. Then rst -> stall_count=0.
- Reset mid-backpressure: skid occupied, rst=1 -> next cycle all outputs at their reset values; the first beat after rst deasserts appears with 1-cycle latency.
